// File: rtl/rk_fb_arbiter_pkg.sv
// Shared framebuffer geometry, address width, clear-FSM states and the packed
// records passed between the arbiter, its write queue and its read pipeline.
package rk_fb_arbiter_pkg;

    localparam int DEF_FB_WIDTH   = 408;
    localparam int DEF_FB_HEIGHT  = 300;
    localparam int ADDR_W         = 18;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              data;
    } wr_ent_t;

    typedef struct packed {
        logic vld;
        logic in_rng;
        logic hit;
        logic fwd;
    } rd_stage_t;

endpackage

// File: rtl/rk_fb_wfifo.sv
// Circular pixel-write queue with a parallel newest-match lookup for forwarding.
// Latency: an entry is visible at the head and to lookup one cycle after push.
// Backpressure: none internally; the caller gates push on full (or full with pop).
module rk_fb_wfifo
    import rk_fb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  wr_ent_t           push_dat,
    input  logic              pop,
    output wr_ent_t           head,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_hit,
    output logic              lk_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    wr_ent_t          mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] idx;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_dat;
    end

    // Walk oldest to newest so the last match seen is the newest one.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = 1'b0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[PTR_W-1:0] + PTR_W'(i);
            if (i < int'(count) && mem[idx].addr == lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = mem[idx].data;
            end
        end
    end

endmodule

// File: rtl/rk_fb_arbiter.sv
// Single-port 1-bit framebuffer arbiter: reads, then clear writes, then queued writes.
// Latency: rd_valid/rd_data 3 cycles after rd_stb; queued writes hit ram_* 1 cycle after pop.
// Backpressure: none to clients; writes beyond the queue depth are dropped and counted.
module rk_fb_arbiter
    import rk_fb_arbiter_pkg::*;
#(
    parameter int FB_WIDTH   = DEF_FB_WIDTH,
    parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_stb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              rd_stb,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_data,
    input  logic              clr_stb,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [7:0]        drop_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_wdata,
    input  logic              ram_q
);

    localparam int FB_SIZE = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0] FB_LIMIT  = ADDR_W'(FB_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

    fb_state_t         state;
    logic [ADDR_W-1:0] clr_addr;
    wr_ent_t           head;
    wr_ent_t           push_dat;
    logic              full, empty, lk_hit, lk_data;
    logic              wr_ok, rd_in, do_pop, push, drop;
    rd_stage_t         s1, s2;

    assign wr_ok    = wr_stb && (wr_addr < FB_LIMIT);
    assign rd_in    = rd_addr < FB_LIMIT;
    assign do_pop   = !rd_stb && (state == S_RUN) && !empty;
    // A full queue still accepts when its head leaves on the same edge.
    assign push     = wr_ok && (!full || do_pop);
    assign drop     = wr_ok && full && !do_pop;
    assign push_dat = '{addr: wr_addr, data: wr_data};

    rk_fb_wfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (do_pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .lk_addr  (rd_addr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (rd_stb) begin
                if (rd_in) ram_addr <= rd_addr;
            end else if (state == S_CLEAR) begin
                ram_addr  <= clr_addr;
                ram_we    <= 1'b1;
                ram_wdata <= 1'b0;
            end else if (!empty) begin
                ram_addr  <= head.addr;
                ram_we    <= 1'b1;
                ram_wdata <= head.data;
            end
        end
    end

    // clr_busy stays up through the clr_done cycle and falls on the following edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_RUN;
            clr_addr <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                S_RUN: begin
                    if (clr_stb) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                        clr_busy <= 1'b1;
                    end else begin
                        clr_busy <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (!rd_stb) begin
                        if (clr_addr == LAST_ADDR) begin
                            state    <= S_RUN;
                            clr_done <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // A read never coincides with a pop, so every queued entry is a forwarding candidate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= '0;
            s2       <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 1'b0;
        end else begin
            s1       <= '{vld: rd_stb, in_rng: rd_in, hit: rd_stb && lk_hit, fwd: lk_data};
            s2       <= s1;
            rd_valid <= s2.vld;
            rd_data  <= s2.vld && (s2.hit ? s2.fwd : (s2.in_rng && ram_q));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rk_fb_arbiter.sv
// Bench for rk_fb_arbiter on a reduced 40x25 buffer: directed scenarios plus random
// traffic, scored against a queue/array model of the framebuffer and its write queue.
`timescale 1ns/1ps
module tb_rk_fb_arbiter;
    import rk_fb_arbiter_pkg::*;

    localparam int FBW     = 40;
    localparam int FBH     = 25;
    localparam int FB_SIZE = FBW * FBH;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_stb = 1'b0, wr_data = 1'b0, rd_stb = 1'b0, clr_stb = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
    logic              rd_valid, rd_data, clr_busy, clr_done, ram_we, ram_wdata;
    logic              ram_q = 1'b0;
    logic [7:0]        drop_cnt;
    logic [ADDR_W-1:0] ram_addr;

    rk_fb_arbiter #(
        .FB_WIDTH   (FBW),
        .FB_HEIGHT  (FBH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_stb    (rd_stb),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .clr_stb   (clr_stb),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .drop_cnt  (drop_cnt),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM, read-before-write.
    bit rmem [FB_SIZE];
    always @(posedge clk) begin
        if (int'(ram_addr) < FB_SIZE) begin
            if (ram_we) rmem[ram_addr] <= ram_wdata;
            ram_q <= rmem[ram_addr];
        end
    end

    typedef struct { int a; bit d; } ent_t;
    typedef struct { int due; int a; bit d; } exp_t;
    typedef struct { bit busy; int drop; int addr; bit we; } st_t;

    bit   mmem [FB_SIZE];
    ent_t mq[$];
    exp_t rd_q[$], wr_q[$];
    int   done_q[$];
    st_t  st_exp[int];
    bit   m_clear = 1'b0;
    int   m_clr = 0, m_drop = 0, m_addr = 0;
    int   n_cmp = 0, n_bad = 0;
    st_t  mon_s;
    exp_t mon_e;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // One slot of the framebuffer model for the edge that samples these inputs.
    function automatic void step(bit rs, int ra, bit ws, int wa, bit wd, bit cs);
        int e = cyc + 1;
        bit was_clear = m_clear;
        bit we = 1'b0;
        if (rs) begin
            bit v = 1'b0;
            if (ra < FB_SIZE) begin
                v = mmem[ra];
                foreach (mq[i]) if (mq[i].a == ra) v = mq[i].d;
                m_addr = ra;
            end
            rd_q.push_back('{e + 2, ra, v});
        end else if (m_clear) begin
            mmem[m_clr] = 1'b0;
            wr_q.push_back('{e, m_clr, 1'b0});
            m_addr = m_clr;
            we = 1'b1;
            if (m_clr == FB_SIZE - 1) begin
                m_clear = 1'b0;
                done_q.push_back(e);
            end else begin
                m_clr++;
            end
        end else if (mq.size() > 0) begin
            ent_t h = mq.pop_front();
            mmem[h.a] = h.d;
            wr_q.push_back('{e, h.a, h.d});
            m_addr = h.a;
            we = 1'b1;
        end
        if (ws && wa < FB_SIZE) begin
            if (mq.size() < DEPTH) mq.push_back('{wa, wd});
            else if (m_drop < 255) m_drop++;
        end
        if (!was_clear && cs) begin
            m_clear = 1'b1;
            m_clr = 0;
        end
        st_exp[e] = '{was_clear || cs, m_drop, m_addr, we};
    endfunction

    task automatic drive(bit rs, int ra, bit ws, int wa, bit wd, bit cs);
        @(negedge clk);
        rd_stb  = rs;
        rd_addr = ADDR_W'(ra);
        wr_stb  = ws;
        wr_addr = ADDR_W'(wa);
        wr_data = wd;
        clr_stb = cs;
        step(rs, ra, ws, wa, wd, cs);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        rd_stb = 1'b0; wr_stb = 1'b0; clr_stb = 1'b0; wr_data = 1'b0;
        rd_addr = '0; wr_addr = '0;
        mq.delete(); rd_q.delete(); wr_q.delete(); done_q.delete(); st_exp.delete();
        m_clear = 1'b0; m_clr = 0; m_drop = 0; m_addr = 0;
        @(negedge clk);
        #1;
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset clr_busy", clr_busy, 0);
        chk("reset clr_done", clr_done, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset ram_we", ram_we, 0);
        chk("reset ram_wdata", ram_wdata, 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 15))
            0:       return FB_SIZE + int'($urandom_range(0, 50));
            1:       return int'($urandom_range(0, FB_SIZE - 1));
            default: return int'($urandom_range(0, 11));
        endcase
    endfunction

    task automatic rnd_cycle(int i);
        bit rs, ws, cs;
        int ra, wa;
        rs = $urandom_range(0, 99) < 45;
        ws = $urandom_range(0, 99) < 60;
        cs = (i == 1000) || ($urandom_range(0, 1499) == 0);
        ra = pick_addr();
        wa = pick_addr();
        drive(rs, ra, ws, wa, 1'($urandom_range(0, 1)), cs);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (st_exp.exists(cyc)) begin
                mon_s = st_exp[cyc];
                st_exp.delete(cyc);
                chk("clr_busy", clr_busy, mon_s.busy);
                chk("drop_cnt", drop_cnt, mon_s.drop);
                chk("ram_addr", ram_addr, mon_s.addr);
                chk("ram_we", ram_we, mon_s.we);
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_valid with no read pending", rd_valid, 0);
                end else begin
                    mon_e = rd_q.pop_front();
                    chk("rd_valid cycle", cyc, mon_e.due);
                    chk($sformatf("rd_data addr %0d", mon_e.a), rd_data, mon_e.d);
                end
            end
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    chk("ram_we with no write pending", ram_we, 0);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("ram write cycle", cyc, mon_e.due);
                    chk("ram write addr", ram_addr, mon_e.a);
                    chk("ram write data", ram_wdata, mon_e.d);
                end
            end
            if (clr_done) begin
                if (done_q.size() == 0) chk("clr_done with no clear ending", clr_done, 0);
                else chk("clr_done cycle", cyc, done_q.pop_front());
            end
        end
    end

    initial begin
        do_reset();

        // Write to 5 still queued when reset hits: it must never reach the RAM.
        drive(1'b1, 10, 1'b1, 5, 1'b1, 1'b0);
        do_reset();
        idle(4);
        drive(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        idle(4);

        drive(1'b0, 0, 1'b1, 100, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 100, 1'b0, 0, 1'b0, 1'b0);
        idle(4);

        // Reads hold the slot for 10 cycles; the 5th write overflows the queue.
        for (int i = 0; i < 10; i++)
            drive(1'b1, (i == 6) ? 201 : int'($urandom_range(0, FB_SIZE - 1)),
                  i < 5, 200 + i, 1'b1, 1'b0);
        idle(8);

        drive(1'b0, 0, 1'b1, 300, 1'b1, 1'b0);
        idle(3);
        drive(1'b1, 300, 1'b1, 300, 1'b1, 1'b0);
        drive(1'b1, 301, 1'b1, 300, 1'b0, 1'b0);
        drive(1'b1, 300, 1'b0, 0, 1'b0, 1'b0);
        idle(4);
        drive(1'b1, 300, 1'b0, 0, 1'b0, 1'b0);
        idle(4);

        // Fill with ones, clear, queue 7<-1 mid-clear, then read everything back.
        for (int a = 0; a < FB_SIZE; a++) drive(1'b0, 0, 1'b1, a, 1'b1, 1'b0);
        idle(4);
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < FB_SIZE + 8; i++) drive(1'b0, 0, i == 300, 7, 1'b1, 1'b0);
        for (int a = 0; a < FB_SIZE; a++) drive(1'b1, a, 1'b0, 0, 1'b0, 1'b0);
        idle(4);

        drive(1'b1, FB_SIZE, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, (1 << ADDR_W) - 1, 1'b0, 0, 1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 270; i++)
            drive(1'b1, int'($urandom_range(0, FB_SIZE - 1)), 1'b1, 600 + (i % 8),
                  1'(i % 2), 1'b0);
        idle(8);

        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        idle(50);
        do_reset();
        idle(30);

        for (int i = 0; i < 3000; i++) rnd_cycle(i);
        idle(2 * FB_SIZE + 20);

        chk("reads never returned", rd_q.size(), 0);
        chk("ram writes never issued", wr_q.size(), 0);
        chk("clr_done never pulsed", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
